// File: rtl/mult_scheduler.sv
// mult_scheduler
//   Shares one dual-gain sign-magnitude multiplier among NREQ requesters.
//   One op is granted per cycle, round-robin. Gains go to the multiplier
//   the cycle after the grant. F is held back GSKEW cycles so that it meets
//   the multiplier's internally delayed G. Each op carries its requester ID
//   down a tag pipe, and the multiplier result is registered with that ID
//   and a one-cycle valid pulse. The multiplier's own valid output is not
//   used.
//
// Optional feature
//   MULT_SCHED_PRIO_EN : when defined, requester 0 has strict priority.
//                        Requesters 1..NREQ-1 round-robin when 0 is idle,
//                        and grants to requester 0 leave the pointer alone.
//
// Ports
//   iClk, iRst              clock (rising edge); synchronous active-high reset
//   iEnable                 0 blocks new grants; ops already in flight finish
//   iReqValid[NREQ]         per-requester request
//   iReqF/iReqG0/iReqG1     17-bit operands per requester, packed at 17*k
//   oReqReady[NREQ]         one-hot combinational grant
//   oF, oG0, oG1            registered multiplier operands
//   iX0, iX1                multiplier results
//   oResValid/oResId/oResX* registered result; ID and X hold between pulses
//   oBusy                   any op in flight
//   oErr                    sticky: an accepted gain had bit 15 set
module mult_scheduler #(
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int GSKEW = 8,
   parameter int MLAT  = 1
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iEnable,
   input  logic [NREQ-1:0]     iReqValid,
   input  logic [17*NREQ-1:0]  iReqF,
   input  logic [17*NREQ-1:0]  iReqG0,
   input  logic [17*NREQ-1:0]  iReqG1,
   output logic [NREQ-1:0]     oReqReady,
   output logic [16:0]         oF,
   output logic [16:0]         oG0,
   output logic [16:0]         oG1,
   input  logic [15:0]         iX0,
   input  logic [15:0]         iX1,
   output logic                oResValid,
   output logic [IDW-1:0]      oResId,
   output logic [15:0]         oResX0,
   output logic [15:0]         oResX1,
   output logic                oBusy,
   output logic                oErr
);
   // Grant to registered result: 1 (gains) + GSKEW + MLAT + 1 (result reg).
   localparam int TDEP = 2 + GSKEW + MLAT;
   localparam int CW   = $clog2(GSKEW + MLAT + 3);

   logic [IDW-1:0]                  ptr_q, ptr_d;
   logic [16:0]                     g0_q, g0_d, g1_q, g1_d, f_q, f_d;
   logic [GSKEW-1:0][16:0]          f_dly_q, f_dly_d;
   logic [TDEP-2:0]                 tag_v_q, tag_v_d;
   logic [TDEP-2:0][IDW-1:0]        tag_id_q, tag_id_d;
   logic                            res_v_q, res_v_d;
   logic [IDW-1:0]                  res_id_q, res_id_d;
   logic [15:0]                     res_x0_q, res_x0_d, res_x1_q, res_x1_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic                            err_q, err_d;

   logic                            found, prio_win;
   logic [IDW-1:0]                  win;
   logic [IDW:0]                    cand;
   logic [16:0]                     sel_f, sel_g0, sel_g1;

   // Arbitration: first valid at or after the pointer, wrapping.
   always_comb begin
      found    = 1'b0;
      prio_win = 1'b0;
      win      = '0;
      cand     = '0;
      if (!iRst && iEnable) begin
`ifdef MULT_SCHED_PRIO_EN
         if (iReqValid[0]) begin
            found    = 1'b1;
            prio_win = 1'b1;
         end
`endif
         for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
            if (!found && iReqValid[cand[IDW-1:0]]) begin
               found = 1'b1;
               win   = cand[IDW-1:0];
            end
         end
      end
   end

   always_comb begin
      oReqReady = '0;
      if (found) oReqReady[win] = 1'b1;
   end

   assign sel_f  = iReqF [int'(win)*17 +: 17];
   assign sel_g0 = iReqG0[int'(win)*17 +: 17];
   assign sel_g1 = iReqG1[int'(win)*17 +: 17];

   always_comb begin
      ptr_d = ptr_q;
      if (found && !prio_win)
         ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);

      // Gains leave with bit 15 cleared; idle slots drive zero.
      g0_d = found ? {sel_g0[16], 1'b0, sel_g0[14:0]} : '0;
      g1_d = found ? {sel_g1[16], 1'b0, sel_g1[14:0]} : '0;

      f_dly_d[0] = found ? sel_f : '0;
      for (int k = 1; k < GSKEW; k++) f_dly_d[k] = f_dly_q[k-1];
      f_d = f_dly_q[GSKEW-1];

      tag_v_d[0]  = found;
      tag_id_d[0] = win;
      for (int k = 1; k < TDEP-1; k++) begin
         tag_v_d[k]  = tag_v_q[k-1];
         tag_id_d[k] = tag_id_q[k-1];
      end

      // The last tag stage lines up with X arriving from the multiplier.
      res_v_d  = tag_v_q[TDEP-2];
      res_id_d = res_id_q;
      res_x0_d = res_x0_q;
      res_x1_d = res_x1_q;
      if (tag_v_q[TDEP-2]) begin
         res_id_d = tag_id_q[TDEP-2];
         res_x0_d = iX0;
         res_x1_d = iX1;
      end

      cnt_d = cnt_q;
      if (found && !res_v_q)      cnt_d = cnt_q + CW'(1);
      else if (!found && res_v_q) cnt_d = cnt_q - CW'(1);

      err_d = err_q | (found & (sel_g0[15] | sel_g1[15]));
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         ptr_q    <= '0;
         g0_q     <= '0;
         g1_q     <= '0;
         f_dly_q  <= '0;
         f_q      <= '0;
         tag_v_q  <= '0;
         tag_id_q <= '0;
         res_v_q  <= 1'b0;
         res_id_q <= '0;
         res_x0_q <= '0;
         res_x1_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         g0_q     <= g0_d;
         g1_q     <= g1_d;
         f_dly_q  <= f_dly_d;
         f_q      <= f_d;
         tag_v_q  <= tag_v_d;
         tag_id_q <= tag_id_d;
         res_v_q  <= res_v_d;
         res_id_q <= res_id_d;
         res_x0_q <= res_x0_d;
         res_x1_q <= res_x1_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign oF        = f_q;
   assign oG0       = g0_q;
   assign oG1       = g1_q;
   assign oResValid = res_v_q;
   assign oResId    = res_id_q;
   assign oResX0    = res_x0_q;
   assign oResX1    = res_x1_q;
   assign oBusy     = (cnt_q != '0);
   assign oErr      = err_q;

endmodule
